// File: rtl/par2ser_pkg.sv
// Shared types and width helpers for the par2ser_feeder serializer slice.
// Bit order is selected at build time by SER_LSB_FIRST_EN (see par2ser_feeder).
package par2ser_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    // Widths for the default build; modules derive their own from parameters.
    localparam int unsigned CNT_W = $clog2(DEF_DATA_W);
    localparam int unsigned PTR_W = $clog2(DEF_FIFO_DEPTH);

    function automatic int unsigned cnt_w(input int unsigned data_w);
        return (data_w < 2) ? 1 : $clog2(data_w);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/par2ser_fifo.sv
// Synchronous FIFO buffering parallel words ahead of the serializer.
// Head entry is read combinationally from storage; pointers wrap mod FIFO_DEPTH.
module par2ser_fifo
    import par2ser_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              push_i,
    input  logic [DATA_W-1:0]                 data_i,
    input  logic                              pop_i,
    output logic [DATA_W-1:0]                 head_o,
    output logic [ptr_w(FIFO_DEPTH):0]        level_o,
    output logic                              full_o,
    output logic                              empty_o
);

    localparam int unsigned PW = ptr_w(FIFO_DEPTH);
    localparam logic [PW:0] FULL_LVL = FIFO_DEPTH[PW:0];

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = count_q;
    assign full_o  = (count_q == FULL_LVL);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/par2ser_feeder.sv
// Word-to-bit serializer feeding the serial pattern detector, with input FIFO.
// Define SER_LSB_FIRST_EN to emit LSB first; default build emits MSB first.
module par2ser_feeder
    import par2ser_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_vld,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_rdy,
    input  logic                          pause,
    output logic                          din_vld,
    output logic                          din,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned CW = cnt_w(DATA_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              din_q, din_d;
    logic              vld_q, vld_d;
    logic              rdy_en_q;

    logic              push, pop;
    logic [DATA_W-1:0] head;
    logic              full, empty;

    par2ser_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .data_i  (in_data),
        .pop_i   (pop),
        .head_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    // rdy_en_q keeps in_rdy low throughout reset without a path from rst_n.
    assign in_rdy = rdy_en_q & ~full;
    assign push   = in_vld & in_rdy;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        vld_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sreg_d  = head;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!pause) begin
                    vld_d = 1'b1;
`ifdef SER_LSB_FIRST_EN
                    din_d  = sreg_q[0];
                    sreg_d = sreg_q >> 1;
`else
                    din_d  = sreg_q[DATA_W-1];
                    sreg_d = sreg_q << 1;
`endif
                    cnt_d = cnt_q + 1'b1;
                    // Reload on the last bit so consecutive words carry no bubble.
                    if (cnt_q == LAST_BIT) begin
                        if (!empty) begin
                            pop    = 1'b1;
                            sreg_d = head;
                            cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            din_q    <= 1'b0;
            vld_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            din_q    <= din_d;
            vld_q    <= vld_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign din_vld = vld_q;
    assign din     = din_q;
    assign busy    = ~empty | (state_q == SHIFT);

endmodule
